// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Elastic pipeline-stage register used between core stages (IF/ID, ID/EX,
// EX/MEM, MEM/WB). It carries a generic control bundle and data bundle with a
// valid/ready handshake. A 2-entry skid buffer (main + skid) gives full
// throughput while keeping in_ready a pure register output.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   When defined, the stall_cnt and bubble_cnt performance counter ports and
//   their logic are present; when undefined they are absent.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   flush      discard all held and incoming entries this cycle
//   in_valid   upstream entry present
//   in_ready   stage can accept (registered, = ~skid_v)
//   in_ctrl    upstream control bundle (all-zero = no-op)
//   in_data    upstream data bundle
//   out_valid  entry presented downstream
//   out_ready  downstream accepts
//   out_ctrl   control bundle, forced to 0 when out_valid=0
//   out_data   data bundle, don't-care when out_valid=0
//   stall_cnt  cycles with out_valid=1 & out_ready=0 (PIPE_PERF_CNT_EN)
//   bubble_cnt cycles with out_valid=0 & out_ready=1 (PIPE_PERF_CNT_EN)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Bit 0 of the encoding is main_v, bit 1 is skid_v; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state, state_nxt;
  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic accept, pop;
  logic ld_main_in, ld_main_skid, ld_skid_in;

  assign main_v = state[0];
  assign skid_v = state[1];

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_ctrl  = main_v ? main_ctrl : '0;
  assign out_data  = main_data;

  assign accept = in_valid & in_ready;
  assign pop    = main_v & out_ready;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid_in   = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt  = ONE;
            ld_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            ld_main_in = 1'b1;
          end else if (accept) begin
            state_nxt  = FULL;
            ld_skid_in = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_nxt    = ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Control bundles are zeroed by flush so a flushed stage reads as a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (ld_main_in)        main_ctrl <= in_ctrl;
      else if (ld_main_skid) main_ctrl <= skid_ctrl;
      if (ld_skid_in)        skid_ctrl <= in_ctrl;
    end
  end

  // Data is left untouched by flush; the load strobes are already zero then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (ld_main_in)        main_data <= in_data;
      else if (ld_main_skid) main_data <= skid_data;
      if (ld_skid_in)        skid_data <= in_data;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // Counters wrap naturally and ignore flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready)  stall_cnt  <= stall_cnt + 1'b1;
      if (!out_valid && out_ready)  bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, elastic pipeline-stage register that replaces the fixed-field ID/EX-style latches between core stages.
- Carries a generic control bundle and a data bundle with valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Flush turns the stage into a bubble with all control bits forced to zero.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
CTRL_W, 8, width of control bundle (RegWrite, MemtoReg, MemWrite, ALUControl, ...); all-zero encodes a no-op
DATA_W, 128, width of data bundle (operands, immediates, register indices, PC+4, instruction)
CNT_W, 32, width of performance counters (used only with PIPE_PERF_CNT_EN)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  discard all held and incoming entries this cycle
in_valid  input  1  upstream entry present
in_ready  output  1  stage can accept; registered, no combinational path from out_ready
in_ctrl  input  CTRL_W  upstream control bundle
in_data  input  DATA_W  upstream data bundle
out_valid  output  1  entry presented downstream
out_ready  input  1  downstream accepts
out_ctrl  output  CTRL_W  control bundle; forced to 0 whenever out_valid=0
out_data  output  DATA_W  data bundle; don't-care when out_valid=0
stall_cnt  output  CNT_W  only with PIPE_PERF_CNT_EN
bubble_cnt  output  CNT_W  only with PIPE_PERF_CNT_EN

Behaviour:
- Storage:
  - main entry (main_v, main_ctrl, main_data) drives the outputs.
  - skid entry (skid_v, skid_ctrl, skid_data) holds overflow.
- Definitions: accept = in_valid & in_ready; pop = out_valid & out_ready.
- out_valid = main_v; out_ctrl = main_v ? main_ctrl : 0; out_data = main_data.
- in_ready = ~skid_v.
- States: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), FULL (main_v=1, skid_v=1). skid_v=1 with main_v=0 is illegal and never reached.
- Transitions when flush=0:
  - EMPTY, accept -> ONE, main <= in.
  - EMPTY, no accept -> EMPTY.
  - ONE, accept & pop -> ONE, main <= in.
  - ONE, accept & ~pop -> FULL, skid <= in.
  - ONE, ~accept & pop -> EMPTY.
  - ONE, neither -> ONE, hold.
  - FULL (in_ready=0), pop -> ONE, main <= skid, skid_v <= 0.
  - FULL, ~pop -> FULL, hold.
- Ordering is strictly FIFO. No entry is ever duplicated or dropped except by flush.
- Latency: an accepted entry appears on out_* the cycle after acceptance when the stage was EMPTY or popping ONE.
- Throughput: one entry per cycle sustained when out_ready=1.
- Flush (synchronous, highest priority):
  - next state EMPTY; main_v <= 0, skid_v <= 0, main_ctrl <= 0, skid_ctrl <= 0.
  - An entry offered the same cycle is discarded.
  - in_ready still reflects current skid_v that cycle.
  - A pop coinciding with flush still completes downstream (the current output was valid this cycle); the entry is then gone.
  - Data registers are not cleared.
- Reset (async, any time including mid-transfer): main_v=0, skid_v=0, main_ctrl=0, skid_ctrl=0, main_data=0, skid_data=0. Hence out_valid=0, out_ctrl=0, out_data=0, in_ready=1. Counters reset to 0.
- Stall equivalence: holding out_ready=0 freezes the stage once FULL, and in_ready then drops. Legacy stall signals map to out_ready=~stall.
- Width rules: ctrl and data are passed bit-exact with no sign handling. CTRL_W>=1, DATA_W>=1.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: stall_cnt and bubble_cnt ports exist.
  - stall_cnt increments each cycle with out_valid=1 & out_ready=0.
  - bubble_cnt increments each cycle with out_valid=0 & out_ready=1.
  - Both wrap modulo 2^CNT_W, are cleared by rst only (not by flush), and are unaffected on flush cycles except by the above conditions.
- Undefined: ports and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-stream with FULL state, CTRL_W=8 -> out_valid=0, out_ctrl=8'h00, out_data=0, in_ready=1 immediately, without waiting for a clock edge.
- Streaming: in_valid=1 every cycle with data 1,2,3,...,10 and out_ready=1 -> out_data 1..10 on consecutive cycles, each one cycle after acceptance; in_ready stays 1.
- Backpressure: push 0xA, 0xB, 0xC with out_ready=0 -> 0xA in main, 0xB in skid, in_ready=0; 0xC held upstream. Raise out_ready -> outputs 0xA, 0xB, 0xC in order, none lost or duplicated.
- Flush: FULL with ctrl 8'hFF in both entries, flush=1 with in_valid=1 (data 0x55) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0x55 never appears at the output.
- Flush+pop: ONE, out_ready=1, flush=1 same cycle -> current entry is observed popped that cycle, then EMPTY next cycle.
- Counters (PIPE_PERF_CNT_EN): 3 cycles out_valid=1/out_ready=0, then 4 cycles empty with out_ready=1 -> stall_cnt=3, bubble_cnt=4. With CNT_W=2, 5 stall cycles -> stall_cnt=1 (wrap).
